// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// Handshake: the caller raises start for one cycle together with is_signed,
// multiplicand and multiplier; the unit accepts it only while busy=0 (IDLE),
// ignores start whenever busy=1, and pulses done for one cycle when product
// becomes valid. product then holds until the next accepted operation finishes.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 2)
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [CW-1:0]      step;
  logic [1:0]         fsm_state;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product, step, fsm_state
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product, step, fsm_state
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier. Operands are widened by one bit so
// signed and unsigned modes share the same signed datapath; the accumulator
// carries one more bit so subtracting the most-negative multiplicand is safe.
// One EVAL + one SHIFT cycle per iteration, N = WIDTH+1 iterations.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic            clk,
  input  logic            rst,
  booth_mult_seq_if.slave bus
);

  localparam int N = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [N:0]         a_q;
  logic [N-1:0]       q_q;
  logic               q1_q;
  logic [N-1:0]       m_q;
  logic [CW-1:0]      step_q;
  logic [2*WIDTH-1:0] product_q;

  // Widened operands: sign bit replicated only in signed mode.
  logic [N-1:0] ext_mcand;
  logic [N-1:0] ext_mplier;
  logic [N:0]   m_sxt;

  // Result of one arithmetic right shift of {A,Q,Q_1}.
  logic [N:0]   a_sh;
  logic [N-1:0] q_sh;
  logic         q1_sh;
  logic [2*N:0] aq_sh;
  logic         last_shift;

  assign ext_mcand  = {bus.is_signed & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign ext_mplier = {bus.is_signed & bus.multiplier[WIDTH-1], bus.multiplier};
  assign m_sxt      = {m_q[N-1], m_q};
  assign {a_sh, q_sh, q1_sh} = {a_q[N], a_q, q_q};
  assign aq_sh      = {a_sh, q_sh};
  assign last_shift = (step_q == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = EVAL;
      EVAL:    state_d = SHIFT;
      SHIFT:   state_d = last_shift ? DONE : EVAL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.fsm_state = state_q;
    bus.product   = product_q;
    bus.step      = step_q;
  end

  // Datapath: operand load, Booth add/subtract, shift and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      step_q    <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q    <= '0;
            q_q    <= ext_mplier;
            q1_q   <= 1'b0;
            m_q    <= ext_mcand;
            step_q <= CW'(N);
          end
        end
        EVAL: begin
          case ({q_q[0], q1_q})
            2'b01:   a_q <= a_q + m_sxt;
            2'b10:   a_q <= a_q - m_sxt;
            default: a_q <= a_q;
          endcase
        end
        SHIFT: begin
          a_q    <= a_sh;
          q_q    <= q_sh;
          q1_q   <= q1_sh;
          step_q <= step_q - CW'(1);
          // Capture on the edge that enters DONE so product is valid with done.
          if (last_shift) begin
            product_q <= aq_sh[2*WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8 with a product scoreboard.
module tb_booth_mult_seq;

  localparam int WIDTH = 8;
  localparam int LAT   = 2 * (WIDTH + 1);

  logic clk;
  logic rst;

  booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "time limit");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product from integer arithmetic on the interpreted operands.
  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic s);
    longint x;
    longint y;
    logic [63:0] p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*WIDTH-1:0];
  endfunction

  // Drive one start pulse; optionally record the expected result.
  task automatic start_op(input string tag, input logic s, input logic [WIDTH-1:0] mc,
                          input logic [WIDTH-1:0] mp, input bit push);
    bus.is_signed    = s;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    bus.start        = 1'b1;
    if (push) exp_q.push_back(model(mc, mp, s));
    cycle();
    acc_cyc   = cyc;
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, bus.busy, 1'b1);
    check({tag, "_step_load"}, bus.step, WIDTH + 1);
  endtask

  // Wait for done, then score latency, product and the single-cycle pulse.
  task automatic wait_done(input string tag);
    bit got;
    logic [2*WIDTH-1:0] e;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1'b1);
    if (got) begin
      check({tag, "_latency"}, cyc - acc_cyc, LAT);
      check({tag, "_step_done"}, bus.step, 0);
      check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_product"}, bus.product, e);
      end
      cycle();
      check({tag, "_done_one_cycle"}, bus.done, 1'b0);
      check({tag, "_idle_after"}, bus.busy, 1'b0);
    end
  endtask

  initial begin
    int extra;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rs;

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    cycle();
    cycle();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_product", bus.product, 16'h0000);
    check("rst_step", bus.step, 0);
    rst = 1'b0;
    cycle();

    // Signed 3 x -4.
    start_op("s3xm4", 1'b1, 8'h03, 8'hFC, 1'b1);
    check("s3xm4_model", exp_q[0], 16'hFFF4);
    wait_done("s3xm4");

    // Most-negative operand corners.
    start_op("m128sq", 1'b1, 8'h80, 8'h80, 1'b1);
    check("m128sq_model", exp_q[0], 16'h4000);
    wait_done("m128sq");
    start_op("m128x127", 1'b1, 8'h80, 8'h7F, 1'b1);
    check("m128x127_model", exp_q[0], 16'hC080);
    wait_done("m128x127");

    // Same bits, both modes.
    start_op("u255sq", 1'b0, 8'hFF, 8'hFF, 1'b1);
    check("u255sq_model", exp_q[0], 16'hFE01);
    wait_done("u255sq");
    start_op("s255sq", 1'b1, 8'hFF, 8'hFF, 1'b1);
    check("s255sq_model", exp_q[0], 16'h0001);
    wait_done("s255sq");

    // Start held high: second op accepted at first IDLE edge; inputs moved mid-op.
    bus.is_signed    = 1'b0;
    bus.multiplicand = 8'd0;
    bus.multiplier   = 8'd77;
    bus.start        = 1'b1;
    exp_q.push_back(model(8'd0, 8'd77, 1'b0));
    cycle();
    acc_cyc = cyc;
    check("held_a_accept", bus.busy, 1'b1);
    bus.multiplicand = 8'd5;
    bus.multiplier   = 8'd5;
    exp_q.push_back(16'h0019);
    wait_done("held_a");
    cycle();
    acc_cyc = cyc;
    check("held_b_accept", bus.busy, 1'b1);
    bus.start        = 1'b0;
    bus.multiplicand = 8'd3;
    bus.multiplier   = 8'd99;
    cycle();
    check("held_product_stable", bus.product, 16'h0000);
    wait_done("held_b");

    // Start while busy is ignored.
    start_op("ign", 1'b0, 8'd7, 8'd3, 1'b1);
    cycle();
    cycle();
    cycle();
    bus.multiplicand = 8'd9;
    bus.multiplier   = 8'd9;
    bus.start        = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("ign_model", exp_q[0], 16'h0015);
    wait_done("ign");
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (bus.done === 1'b1) extra++;
    end
    check("ign_no_extra_done", extra, 0);
    check("ign_sb_empty", exp_q.size(), 0);

    // Reset in the middle of an operation.
    start_op("abort", 1'b0, 8'd100, 8'd3, 1'b0);
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_product", bus.product, 16'h0000);
    check("abort_step", bus.step, 0);
    rst = 1'b0;
    cycle();
    start_op("r7x6", 1'b0, 8'd7, 8'd6, 1'b1);
    check("r7x6_model", exp_q[0], 16'h002A);
    wait_done("r7x6");

    // Random operands in both modes.
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      start_op("rand", rs, ra, rb, 1'b1);
      wait_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
